if_stage: RTL and testbench



---
 rtl/if_stage.sv | 160 ++++++++++++++++
 tb/tb_if_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, issues word fetches over req/ack, and buffers results toward decode.
// Define IF_BYPASS_EN to forward a returning fetch straight to decode when the buffer is empty.
module if_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_addr,
  input  logic        id_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic [63:0]       addr_q, addr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       fifo_inst_q [FIFO_DEPTH];
  logic [31:0]       fifo_inst_d [FIFO_DEPTH];
  logic [63:0]       fifo_pc_q   [FIFO_DEPTH];
  logic [63:0]       fifo_pc_d   [FIFO_DEPTH];

  logic [63:0]       redir_pc;
  logic              fifo_empty;
  logic              fetch_done;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count_after;

  // Low address bits of a redirect target are forced to zero so every fetch stays word aligned.
  assign redir_pc   = redirect_pc & ~64'h3;
  assign fifo_empty = (count_q == '0);
  assign fetch_done = (state_q == REQ) && mem_ack && !redirect_valid;
  assign pop        = !fifo_empty && id_ready && !redirect_valid;
  assign mem_req    = (state_q != IDLE);
  assign mem_addr   = addr_q;

`ifdef IF_BYPASS_EN
  logic bypass;
  assign bypass = fetch_done && fifo_empty;
  assign push   = fetch_done && !(bypass && id_ready);
`else
  assign push   = fetch_done;
`endif

  assign count_after = count_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    inst_valid = !fifo_empty;
    inst       = fifo_empty ? 32'h0 : fifo_inst_q[rd_ptr_q];
    inst_addr  = fifo_empty ? 64'h0 : fifo_pc_q[rd_ptr_q];
`ifdef IF_BYPASS_EN
    if (bypass) begin
      inst_valid = 1'b1;
      inst       = mem_rdata;
      inst_addr  = pc_q;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_after;
    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;

    if (push) begin
      fifo_inst_d[wr_ptr_q] = mem_rdata;
      fifo_pc_d[wr_ptr_q]   = pc_q;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (!redirect_valid && (count_q < DEPTH_C)) begin
          state_d = REQ;
          addr_d  = pc_q;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          // An unanswered request cannot be withdrawn, so it is left to drain in FLUSH.
          if (mem_ack) begin
            addr_d = redir_pc;
          end else begin
            state_d = FLUSH;
          end
        end else if (mem_ack) begin
          pc_d = pc_q + 64'd4;
          if (count_after < DEPTH_C) begin
            addr_d = pc_q + 64'd4;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (mem_ack) begin
          state_d = REQ;
          addr_d  = redirect_valid ? redir_pc : pc_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      pc_d     = redir_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      fifo_inst_q <= fifo_inst_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed vector table, hand-written corner sequences and a random run
// checked against a queue-based fetch model.
module tb_if_stage;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          DEPTH    = 2;
`ifdef IF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_addr;
  logic        id_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  if_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_addr      (inst_addr),
    .id_ready       (id_ready)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of buffered {addr, data} pairs plus the outstanding-request view.
  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_pc;
  bit          m_busy;
  bit          m_stale;
  logic [63:0] m_req_addr;

  typedef struct {
    bit          rst_before;
    bit          ack;
    logic [31:0] rdata;
    bit          redir;
    logic [63:0] rpc;
    bit          rdy;
    bit          exp_req;
    logic [63:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_inst;
    logic [63:0] exp_iaddr;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(bit rb, bit ack, logic [31:0] rd, bit rv, logic [63:0] rp, bit rdy,
                               bit er, logic [63:0] ea, bit ev, logic [31:0] ei, logic [63:0] eia,
                               string nm);
    vec_t v;
    v.rst_before = rb;  v.ack = ack;      v.rdata = rd;    v.redir = rv;
    v.rpc = rp;         v.rdy = rdy;      v.exp_req = er;  v.exp_addr = ea;
    v.exp_valid = ev;   v.exp_inst = ei;  v.exp_iaddr = eia;
    v.name = nm;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    m_pc       = RESET_PC;
    m_busy     = 1'b0;
    m_stale    = 1'b0;
    m_req_addr = '0;
  endtask

  task automatic modelCompare();
    bit          byp;
    bit          ev;
    logic [31:0] ei;
    logic [63:0] eia;
    byp = BYP && m_busy && !m_stale && mem_ack && !redirect_valid && (q.size() == 0);
    ev  = (q.size() > 0) || byp;
    ei  = (q.size() > 0) ? q[0].data : (byp ? mem_rdata : 32'h0);
    eia = (q.size() > 0) ? q[0].addr : (byp ? m_pc : 64'h0);
    checkOutput("model_req", {63'h0, mem_req}, {63'h0, m_busy});
    if (m_busy) checkOutput("model_addr", mem_addr, m_req_addr);
    checkOutput("model_valid", {63'h0, inst_valid}, {63'h0, ev});
    checkOutput("model_inst", {32'h0, inst}, {32'h0, ei});
    checkOutput("model_iaddr", inst_addr, eia);
  endtask

  task automatic modelStep();
    int   sz0;
    bit   acc;
    ent_t e;
    sz0 = q.size();
    acc = m_busy && mem_ack;
    if (redirect_valid) begin
      q.delete();
      m_pc = redirect_pc & ~64'h3;
      if (acc) begin
        m_req_addr = m_pc;
        m_stale    = 1'b0;
      end else if (m_busy) begin
        m_stale = 1'b1;
      end
    end else begin
      if (sz0 > 0 && id_ready) void'(q.pop_front());
      if (!m_busy) begin
        if (sz0 < DEPTH) begin
          m_busy     = 1'b1;
          m_req_addr = m_pc;
        end
      end else if (acc && m_stale) begin
        m_stale    = 1'b0;
        m_req_addr = m_pc;
      end else if (acc) begin
        if (!(BYP && sz0 == 0 && id_ready)) begin
          e.addr = m_pc;
          e.data = mem_rdata;
          q.push_back(e);
        end
        m_pc = m_pc + 64'd4;
        if (q.size() < DEPTH) m_req_addr = m_pc;
        else m_busy = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input bit ack, input logic [31:0] rd, input bit rv,
                               input logic [63:0] rp, input bit rdy);
    @(negedge clk);
    mem_ack        = ack;
    mem_rdata      = rd;
    redirect_valid = rv;
    redirect_pc    = rp;
    id_ready       = rdy;
    #1;
    modelCompare();
    modelStep();
  endtask

  task automatic doReset();
    rst = 1'b1;
    mem_ack = 1'b0; mem_rdata = '0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_req", {63'h0, mem_req}, 64'h0);
    checkOutput("rst_addr", mem_addr, 64'h0);
    checkOutput("rst_valid", {63'h0, inst_valid}, 64'h0);
    checkOutput("rst_inst", {32'h0, inst}, 64'h0);
    checkOutput("rst_iaddr", inst_addr, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    modelCompare();
    modelStep();
  endtask

  initial begin
    // Directed table; inst fields assume the registered (non-bypass) path.
    vecs.push_back(mkv(1, 1, 32'h00100093, 0, 0, 1, 1, 64'h80000000, 0, 32'h0, 64'h0, "a1"));
    vecs.push_back(mkv(0, 1, 32'h00100093, 0, 0, 1, 1, 64'h80000004, 1, 32'h00100093, 64'h80000000, "a2"));
    vecs.push_back(mkv(0, 1, 32'h00100093, 0, 0, 1, 1, 64'h80000008, 1, 32'h00100093, 64'h80000004, "a3"));
    vecs.push_back(mkv(0, 1, 32'h00100093, 0, 0, 1, 1, 64'h8000000C, 1, 32'h00100093, 64'h80000008, "a4"));
    vecs.push_back(mkv(1, 1, 32'hAAAA0001, 0, 0, 0, 1, 64'h80000000, 0, 32'h0, 64'h0, "b1"));
    vecs.push_back(mkv(0, 1, 32'hAAAA0002, 0, 0, 0, 1, 64'h80000004, 1, 32'hAAAA0001, 64'h80000000, "b2"));
    vecs.push_back(mkv(0, 1, 32'hAAAA0003, 0, 0, 0, 0, 64'h0, 1, 32'hAAAA0001, 64'h80000000, "b3"));
    vecs.push_back(mkv(0, 0, 32'h0, 0, 0, 1, 0, 64'h0, 1, 32'hAAAA0001, 64'h80000000, "b4"));
    vecs.push_back(mkv(0, 0, 32'h0, 0, 0, 0, 0, 64'h0, 1, 32'hAAAA0002, 64'h80000004, "b5"));
    vecs.push_back(mkv(0, 0, 32'h0, 0, 0, 0, 1, 64'h80000008, 1, 32'hAAAA0002, 64'h80000004, "b6"));
    vecs.push_back(mkv(1, 0, 32'h0, 1, 64'h80000103, 1, 1, 64'h80000000, 0, 32'h0, 64'h0, "c1"));
    vecs.push_back(mkv(0, 0, 32'h0, 0, 0, 1, 1, 64'h80000000, 0, 32'h0, 64'h0, "c2"));
    vecs.push_back(mkv(0, 0, 32'h0, 0, 0, 1, 1, 64'h80000000, 0, 32'h0, 64'h0, "c3"));
    vecs.push_back(mkv(0, 1, 32'hDEADBEEF, 0, 0, 1, 1, 64'h80000000, 0, 32'h0, 64'h0, "c4"));
    vecs.push_back(mkv(0, 0, 32'h0, 0, 0, 1, 1, 64'h80000100, 0, 32'h0, 64'h0, "c5"));
    vecs.push_back(mkv(0, 1, 32'h00000013, 0, 0, 0, 1, 64'h80000100, 0, 32'h0, 64'h0, "c6"));
    vecs.push_back(mkv(0, 0, 32'h0, 0, 0, 0, 1, 64'h80000104, 1, 32'h00000013, 64'h80000100, "c7"));
    vecs.push_back(mkv(1, 1, 32'h12345678, 0, 0, 0, 1, 64'h80000000, 0, 32'h0, 64'h0, "d1"));
    vecs.push_back(mkv(0, 1, 32'hCAFEF00D, 1, 64'h2000, 1, 1, 64'h80000004, 1, 32'h12345678, 64'h80000000, "d2"));
    vecs.push_back(mkv(0, 0, 32'h0, 0, 0, 0, 1, 64'h2000, 0, 32'h0, 64'h0, "d3"));
    vecs.push_back(mkv(0, 1, 32'h00000073, 0, 0, 0, 1, 64'h2000, 0, 32'h0, 64'h0, "d4"));
    vecs.push_back(mkv(0, 0, 32'h0, 0, 0, 0, 1, 64'h2004, 1, 32'h00000073, 64'h2000, "d5"));

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) doReset();
      applyStimulus(vecs[i].ack, vecs[i].rdata, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
      checkOutput({vecs[i].name, "_req"}, {63'h0, mem_req}, {63'h0, vecs[i].exp_req});
      if (vecs[i].exp_req) checkOutput({vecs[i].name, "_addr"}, mem_addr, vecs[i].exp_addr);
`ifndef IF_BYPASS_EN
      checkOutput({vecs[i].name, "_valid"}, {63'h0, inst_valid}, {63'h0, vecs[i].exp_valid});
      checkOutput({vecs[i].name, "_inst"}, {32'h0, inst}, {32'h0, vecs[i].exp_inst});
      checkOutput({vecs[i].name, "_iaddr"}, inst_addr, vecs[i].exp_iaddr);
`endif
    end

    // Fetch-to-decode latency with an empty buffer.
    doReset();
    applyStimulus(1, 32'h0BADC0DE, 0, 0, 0);
`ifdef IF_BYPASS_EN
    checkOutput("lat_same_valid", {63'h0, inst_valid}, 64'h1);
    checkOutput("lat_same_inst", {32'h0, inst}, {32'h0, 32'h0BADC0DE});
`else
    checkOutput("lat_same_valid", {63'h0, inst_valid}, 64'h0);
`endif
    applyStimulus(0, 32'h0, 0, 0, 0);
    checkOutput("lat_next_valid", {63'h0, inst_valid}, 64'h1);
    checkOutput("lat_next_inst", {32'h0, inst}, {32'h0, 32'h0BADC0DE});

    // PC wraps past the top of the 64-bit space; unaligned redirect bits dropped.
    doReset();
    applyStimulus(0, 32'h0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    applyStimulus(1, 32'h0, 0, 0, 0);
    applyStimulus(1, 32'h00000013, 0, 0, 0);
    checkOutput("wrap_addr_top", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(0, 32'h0, 0, 0, 0);
    checkOutput("wrap_addr_zero", mem_addr, 64'h0);
    checkOutput("wrap_iaddr", inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);

    // Asynchronous reset in the middle of a fetch with data buffered.
    doReset();
    applyStimulus(1, 32'h11112222, 0, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", {63'h0, inst_valid}, 64'h0);
    checkOutput("arst_req", {63'h0, mem_req}, 64'h0);
    checkOutput("arst_inst", {32'h0, inst}, 64'h0);
    doReset();
    applyStimulus(0, 32'h0, 0, 0, 1);
    checkOutput("arst_restart_req", {63'h0, mem_req}, 64'h1);
    checkOutput("arst_restart_addr", mem_addr, RESET_PC);

    // Random traffic against the reference model.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      logic [63:0] rp;
      case ($urandom % 4)
        0: rp = {$urandom, $urandom};
        1: rp = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
        default: rp = 64'h8000_0000 + 64'($urandom_range(0, 255));
      endcase
      if ($urandom % 400 == 0) doReset();
      applyStimulus(($urandom % 10) < 6, $urandom, ($urandom % 20) == 0, rp, ($urandom % 10) < 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
